// File: rtl/quad_encoder_emu.sv
// Quadrature incremental-encoder emulator: A/B/Z outputs from a programmable step rate,
// with continuous-run and counted-move modes and registered position readback.
module quad_encoder_emu #(
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned PPR        = 1024,
  parameter int unsigned POS_WIDTH  = 16,
  parameter int unsigned STEP_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  dir,
  input  logic [CNT_WIDTH-1:0]  step_period,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [STEP_WIDTH-1:0] cmd_steps,
  input  logic                  cmd_dir,
  input  logic                  abort,
  output logic                  enc_a,
  output logic                  enc_b,
  output logic                  enc_z,
  output logic [POS_WIDTH-1:0]  pos,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCont = 2'd1;
  localparam logic [1:0] StMove = 2'd2;

  localparam logic [POS_WIDTH-1:0]  PosMax    = POS_WIDTH'(4 * PPR - 1);
  localparam logic [CNT_WIDTH-1:0]  MinPeriod = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0]  CntOne    = CNT_WIDTH'(1);
  localparam logic [STEP_WIDTH-1:0] StepOne   = STEP_WIDTH'(1);

  logic [1:0]            state_q, state_d;
  logic [CNT_WIDTH-1:0]  presc_q, presc_d;
  logic [CNT_WIDTH-1:0]  period_q, period_d;
  logic [STEP_WIDTH-1:0] remaining_q, remaining_d;
  logic                  move_dir_q, move_dir_d;
  logic [POS_WIDTH-1:0]  pos_q, pos_d;
  logic                  enc_a_q, enc_a_d;
  logic                  enc_b_q, enc_b_d;
  logic                  enc_z_q, enc_z_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cmd_ready_q, cmd_ready_d;

  logic step_fire;
  logic step_en;
  logic step_dir;

  // The period is re-sampled whenever the prescaler sits at 0, so a new rate only
  // applies from the next step boundary.
  always_comb begin
    period_d = period_q;
    if (presc_q == '0) begin
      period_d = (step_period < MinPeriod) ? MinPeriod : step_period;
    end
  end

  assign step_fire = (state_q != StIdle) && (presc_q != '0) && (presc_q == period_q - CntOne);

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    remaining_d = remaining_q;
    move_dir_d  = move_dir_q;
    done_d      = 1'b0;
    step_en     = 1'b0;
    step_dir    = dir;

    case (state_q)
      StIdle: begin
        presc_d = '0;
        if (cmd_valid) begin
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            remaining_d = cmd_steps;
            move_dir_d  = cmd_dir;
            state_d     = StMove;
          end
        end else if (run) begin
          state_d = StCont;
        end
      end

      StCont: begin
        if (!run) begin
          state_d = StIdle;
          presc_d = '0;
        end else if (step_fire) begin
          step_en = 1'b1;
          presc_d = '0;
        end else begin
          presc_d = presc_q + CntOne;
        end
      end

      StMove: begin
        step_dir = move_dir_q;
        // A final step wins over a coincident abort so the move still completes.
        if (step_fire && (remaining_q == StepOne)) begin
          step_en     = 1'b1;
          presc_d     = '0;
          remaining_d = '0;
          state_d     = StIdle;
          done_d      = 1'b1;
        end else if (abort) begin
          presc_d     = '0;
          remaining_d = '0;
          state_d     = StIdle;
        end else if (step_fire) begin
          step_en     = 1'b1;
          presc_d     = '0;
          remaining_d = remaining_q - StepOne;
        end else begin
          presc_d = presc_q + CntOne;
        end
      end

      default: begin
        state_d = StIdle;
        presc_d = '0;
      end
    endcase
  end

  always_comb begin
    pos_d = pos_q;
    if (step_en) begin
      if (step_dir) begin
        pos_d = (pos_q == PosMax) ? '0 : pos_q + POS_WIDTH'(1);
      end else begin
        pos_d = (pos_q == '0) ? PosMax : pos_q - POS_WIDTH'(1);
      end
    end
    // Quadrature state is pos mod 4: (A,B) = 00, 10, 11, 01.
    enc_a_d     = pos_d[1] ^ pos_d[0];
    enc_b_d     = pos_d[1];
    enc_z_d     = (pos_d == '0);
    busy_d      = (state_d != StIdle);
    cmd_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      presc_q     <= '0;
      period_q    <= MinPeriod;
      remaining_q <= '0;
      move_dir_q  <= 1'b0;
      pos_q       <= '0;
      enc_a_q     <= 1'b0;
      enc_b_q     <= 1'b0;
      enc_z_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      period_q    <= period_d;
      remaining_q <= remaining_d;
      move_dir_q  <= move_dir_d;
      pos_q       <= pos_d;
      enc_a_q     <= enc_a_d;
      enc_b_q     <= enc_b_d;
      enc_z_q     <= enc_z_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign enc_a     = enc_a_q;
  assign enc_b     = enc_b_q;
  assign enc_z     = enc_z_q;
  assign pos       = pos_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_quad_encoder_emu.sv
// Scoreboard bench for quad_encoder_emu: stimulus queues the expected output changes with
// their cycle stamps; a monitor pops one entry every time the DUT outputs change.
module tb_quad_encoder_emu;

  localparam int unsigned CW  = 32;
  localparam int unsigned PPR = 4;
  localparam int unsigned PW  = 16;
  localparam int unsigned SW  = 32;
  localparam int unsigned VW  = PW + 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run, dir, cmd_valid, cmd_dir, abort;
  logic [CW-1:0] step_period;
  logic [SW-1:0] cmd_steps;
  logic          cmd_ready, enc_a, enc_b, enc_z, busy, done;
  logic [PW-1:0] pos;

  quad_encoder_emu #(
    .CNT_WIDTH (CW),
    .PPR       (PPR),
    .POS_WIDTH (PW),
    .STEP_WIDTH(SW)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .dir        (dir),
    .step_period(step_period),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_steps  (cmd_steps),
    .cmd_dir    (cmd_dir),
    .abort      (abort),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
    .enc_z      (enc_z),
    .pos        (pos),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [VW-1:0] vec;
  } evt_t;

  evt_t          sb_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            evt_n    = 0;
  logic [VW-1:0] prev_vec = '1;
  logic [VW-1:0] cur_vec;
  evt_t          exp_e;
  logic          end_req  = 1'b0;
  logic          mon_done = 1'b0;
  event          mon_ev;

  // Expected output vector {A, B, Z, pos, done, busy, cmd_ready} for a given position.
  function automatic logic [VW-1:0] mk(input int p, input bit d, input bit b, input bit r);
    logic [1:0]    ab;
    logic [PW-1:0] pv;
    pv = PW'(p);
    case (p % 4)
      0:       ab = 2'b00;
      1:       ab = 2'b10;
      2:       ab = 2'b11;
      default: ab = 2'b01;
    endcase
    return {ab, (p == 0), pv, d, b, r};
  endfunction

  task automatic push(input int c, input int p, input bit d, input bit b, input bit r);
    evt_t e;
    e.cyc = c;
    e.vec = mk(p, d, b, r);
    sb_q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk or mon_ev) begin
    cur_vec = {enc_a, enc_b, enc_z, pos, done, busy, cmd_ready};
    if (cur_vec !== prev_vec) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_change cyc=%0d got vec=%h required no change", cyc, cur_vec);
      end else begin
        exp_e = sb_q.pop_front();
        if (cur_vec === exp_e.vec && cyc == exp_e.cyc) begin
          n_pass++;
        end else begin
          $display("FAIL evt%0d got cyc=%0d pos=%0d abz=%b%b%b done=%b busy=%b rdy=%b (vec=%h) required cyc=%0d vec=%h",
                   evt_n, cyc, pos, enc_a, enc_b, enc_z, done, busy, cmd_ready, cur_vec,
                   exp_e.cyc, exp_e.vec);
        end
      end
      evt_n++;
      prev_vec = cur_vec;
    end
    if (end_req && !mon_done) begin
      n_checks++;
      if (sb_q.size() == 0) n_pass++;
      else $display("FAIL queue_drained got %0d pending (next cyc=%0d) required 0",
                    sb_q.size(), sb_q[0].cyc);
      mon_done = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  int base, t, c;

  initial begin
    rst_n = 1'b1; run = 1'b0; dir = 1'b0; step_period = '0;
    cmd_valid = 1'b0; cmd_steps = '0; cmd_dir = 1'b0; abort = 1'b0;
    #1 rst_n = 1'b0;
    push(1, 0, 0, 0, 1);
    @(negedge clk);
    @(negedge clk);

    // Continuous forward run at 10 clocks per step, full wrap then on to pos 5.
    base = cyc + 1;
    rst_n = 1'b1; step_period = 10; dir = 1'b1; run = 1'b1;
    push(base, 0, 0, 1, 0);
    for (int k = 1; k <= 21; k++) push(base + 10 * k, k % 16, 0, 1, 0);
    // Reverse from pos 5 through the 0 -> 15 wrap.
    for (int k = 1; k <= 7; k++) push(base + 210 + 10 * k, (21 - k) % 16, 0, 1, 0);
    wait_cyc(base + 210);
    dir = 1'b0;

    // Rate change mid-step: current step still takes 10, the rest take 4.
    t = base + 280;
    wait_cyc(t + 3);
    step_period = 4;
    push(t + 10, 13, 0, 1, 0);
    push(t + 14, 12, 0, 1, 0);
    push(t + 18, 11, 0, 1, 0);
    wait_cyc(t + 18);
    run = 1'b0;
    push(t + 19, 11, 0, 0, 1);

    // step_period = 0 behaves as 2.
    wait_cyc(t + 21);
    c = cyc;
    step_period = 0; dir = 1'b1; run = 1'b1;
    push(c + 1, 11, 0, 1, 0);
    push(c + 3, 12, 0, 1, 0);
    push(c + 5, 13, 0, 1, 0);
    push(c + 7, 14, 0, 1, 0);
    wait_cyc(c + 7);
    run = 1'b0;
    push(c + 8, 14, 0, 0, 1);

    // Reset asserted mid-move clears outputs immediately, no done.
    wait_cyc(c + 10);
    c = cyc;
    step_period = 3; cmd_steps = 5; cmd_dir = 1'b1; cmd_valid = 1'b1;
    push(c + 1, 14, 0, 1, 0);
    push(c + 4, 15, 0, 1, 0);
    wait_cyc(c + 1);
    cmd_valid = 1'b0;
    wait_cyc(c + 5);
    push(c + 5, 0, 0, 0, 1);
    #1 rst_n = 1'b0;
    #1 -> mon_ev;
    wait_cyc(c + 7);
    rst_n = 1'b1;

    // Counted move of 7 at period 3 from pos 0.
    wait_cyc(c + 9);
    c = cyc;
    cmd_steps = 7; cmd_dir = 1'b1; cmd_valid = 1'b1;
    push(c + 1, 0, 0, 1, 0);
    for (int k = 1; k <= 6; k++) push(c + 1 + 3 * k, k, 0, 1, 0);
    push(c + 22, 7, 1, 0, 1);
    push(c + 23, 7, 0, 0, 1);
    wait_cyc(c + 1);
    cmd_valid = 1'b0;

    // Zero-length move: done one cycle after acceptance, pos unchanged.
    wait_cyc(c + 26);
    c = cyc;
    cmd_steps = 0; cmd_valid = 1'b1;
    push(c + 1, 7, 1, 0, 1);
    push(c + 2, 7, 0, 0, 1);
    wait_cyc(c + 1);
    cmd_valid = 1'b0;

    // run and cmd_valid together: the reverse move is taken, run/dir ignored.
    wait_cyc(c + 5);
    c = cyc;
    cmd_steps = 4; cmd_dir = 1'b0; dir = 1'b1; run = 1'b1; cmd_valid = 1'b1;
    push(c + 1, 7, 0, 1, 0);
    push(c + 4, 6, 0, 1, 0);
    push(c + 7, 5, 0, 1, 0);
    push(c + 10, 4, 0, 1, 0);
    push(c + 13, 3, 1, 0, 1);
    push(c + 14, 3, 0, 0, 1);
    wait_cyc(c + 1);
    cmd_valid = 1'b0;
    wait_cyc(c + 2);
    run = 1'b0;

    // Abort with 3 steps remaining: idle next edge, no done, pos frozen.
    wait_cyc(c + 17);
    c = cyc;
    cmd_steps = 6; cmd_dir = 1'b1; cmd_valid = 1'b1;
    push(c + 1, 3, 0, 1, 0);
    push(c + 4, 4, 0, 1, 0);
    push(c + 7, 5, 0, 1, 0);
    push(c + 10, 6, 0, 1, 0);
    push(c + 11, 6, 0, 0, 1);
    wait_cyc(c + 1);
    cmd_valid = 1'b0;
    wait_cyc(c + 10);
    abort = 1'b1;
    wait_cyc(c + 11);
    abort = 1'b0;

    // Abort coinciding with the final step: step executes and done pulses.
    wait_cyc(c + 15);
    c = cyc;
    cmd_steps = 2; cmd_dir = 1'b1; cmd_valid = 1'b1;
    push(c + 1, 6, 0, 1, 0);
    push(c + 4, 7, 0, 1, 0);
    push(c + 7, 8, 1, 0, 1);
    push(c + 8, 8, 0, 0, 1);
    wait_cyc(c + 1);
    cmd_valid = 1'b0;
    wait_cyc(c + 6);
    abort = 1'b1;
    wait_cyc(c + 7);
    abort = 1'b0;

    wait_cyc(c + 20);
    end_req = 1'b1;
    for (int i = 0; i < 4 && !mon_done; i++) @(negedge clk);
    if (!mon_done) $display("FAIL monitor_end got no response required drain check");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/quad_encoder_emu.md
Name: quad_encoder_emu

Overview:
- Synchronous quadrature incremental-encoder emulator: generates A/B/Z outputs from a programmable step rate, direction and mode.
- Used as a stimulus source for the encoder-decoder and motor-control paths on the controller FPGA.
- Supersedes the fixed 50 % square-wave test generator: no derived clocks, runtime speed and direction, index pulse, position readback, and a counted-move command.

Parameters:
- CNT_WIDTH, 32, width of step_period and the internal prescaler.
- PPR, 1024, encoder lines per revolution; one revolution is 4*PPR quadrature counts.
- POS_WIDTH, 16, width of pos; must satisfy 2^POS_WIDTH >= 4*PPR.
- STEP_WIDTH, 32, width of cmd_steps and the remaining-steps counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  continuous-run request (level)
- dir  in  1  continuous-run direction: 1 = forward (A leads B), 0 = reverse
- step_period  in  CNT_WIDTH  clocks per quadrature state; values 0 and 1 are treated as 2
- cmd_valid  in  1  counted-move request
- cmd_ready  out  1  move command accepted when cmd_valid && cmd_ready
- cmd_steps  in  STEP_WIDTH  number of quadrature counts to move
- cmd_dir  in  1  direction of the counted move
- abort  in  1  terminate a counted move immediately
- enc_a  out  1  quadrature channel A
- enc_b  out  1  quadrature channel B
- enc_z  out  1  index pulse
- pos  out  POS_WIDTH  current quadrature count, 0..4*PPR-1
- busy  out  1  high in any run state
- done  out  1  one-cycle pulse when a counted move completes

Behaviour:
- Single clock domain. All outputs registered.
- Reset values: enc_a=0, enc_b=0, pos=0, enc_z=1, busy=0, done=0, cmd_ready=1, FSM=IDLE, prescaler=0, remaining=0.
- Quadrature states s=0..3 map to (A,B) = (0,0), (1,0), (1,1), (0,1).
- Forward step: s+1 mod 4, pos+1, wrapping 4*PPR-1 -> 0. Reverse step: s-1 mod 4, pos-1, wrapping 0 -> 4*PPR-1.
- s always equals pos mod 4. enc_z = (pos==0), updated on the same edge as pos.
- Prescaler: P = max(step_period, 2), sampled when the prescaler is 0, so changes take effect at the next step boundary.
  - In a run state the prescaler increments each cycle.
  - When prescaler == P-1, a step fires: outputs update on that edge and the prescaler returns to 0.
  - The first step occurs P clocks after the edge that entered the run state.
  - On leaving a run state the prescaler clears; a partial step is discarded.
- FSM states: IDLE, CONT, MOVE.
  - IDLE: cmd_ready=1. cmd_valid has priority over run. cmd_valid -> latch cmd_steps into remaining and cmd_dir, go to MOVE. Otherwise run=1 -> CONT.
  - IDLE with cmd_steps==0 accepted: stay in IDLE, done=1 next cycle, no step.
  - CONT: dir is sampled at each step, so a direction reversal takes effect on the next step. run=0 -> IDLE on the next edge; outputs hold their current state.
  - MOVE: run and dir are ignored; remaining decrements per step. The edge executing the final step also moves the FSM to IDLE with done=1 for exactly one cycle.
  - MOVE with abort=1 -> IDLE on the next edge, no done pulse. If abort coincides with the final step, the step executes and done is asserted.
- cmd_ready=0 in CONT and MOVE. cmd_valid is ignored there and is not queued.
- busy=1 in CONT and MOVE.
- pos, enc_a, enc_b and enc_z retain their values through IDLE; only reset clears them.
- Reset asserted mid-move returns everything to reset values asynchronously, with no done pulse.

Test Plan:
- PPR=4, step_period=10, run=1, dir=1 from reset:
  - first A rise 10 clks after CONT entry;
  - (A,B) sequence 00,10,11,01,00 every 10 clks;
  - pos 0..15 then wraps to 0;
  - enc_z high exactly when pos==0.
- Same setup, dir toggled to 0 mid-run at pos=5: next step gives pos=4 with (A,B)=(0,0); reverse sequence 00,01,11,10 follows; 0 -> 15 wrap checked.
- cmd_steps=7, cmd_dir=1, step_period=3 from pos=0:
  - cmd_ready drops on acceptance;
  - exactly 7 steps, 3 clks apart, ending at pos=7;
  - done pulses for one cycle and cmd_ready returns high in the same cycle.
- Edge values:
  - step_period=0, run=1: steps every 2 clks.
  - cmd_steps=0: done pulses one cycle after acceptance, pos unchanged.
  - run and cmd_valid asserted together in IDLE: MOVE is entered.
- Interruptions:
  - abort at remaining=3: IDLE next edge, no done, pos frozen.
  - rst_n pulsed low mid-move: all outputs return to reset values immediately.
  - step_period changed 10 -> 4 mid-step: the current step completes at 10, following steps at 4.
